// File: rtl/distance_argmin_pipe_if.sv
`default_nettype none
// ============================================================================
// distance_argmin_pipe_if : sample-in / result-out handshake bundle for the
// pipelined argmin. Revision: 1.0
// ============================================================================
interface distance_argmin_pipe_if #(
  parameter int N_CORES = 16,
  parameter int DIST_W  = 11,
  parameter int TAG_W   = 8,
  parameter int IDX_W   = $clog2(N_CORES)
);
  logic                        in_valid;
  logic                        in_ready;
  logic [N_CORES*DIST_W-1:0]   in_dist;
  logic [N_CORES-1:0]          in_en;
  logic [TAG_W-1:0]            in_tag;
  logic                        out_valid;
  logic                        out_ready;
  logic [N_CORES-1:0]          out_onehot;
  logic [IDX_W-1:0]            out_idx;
  logic [DIST_W-1:0]           out_min;
  logic                        out_none;
  logic [TAG_W-1:0]            out_tag;

  modport master (
    output in_valid, in_dist, in_en, in_tag, out_ready,
    input  in_ready, out_valid, out_onehot, out_idx, out_min, out_none, out_tag
  );

  modport slave (
    input  in_valid, in_dist, in_en, in_tag, out_ready,
    output in_ready, out_valid, out_onehot, out_idx, out_min, out_none, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/distance_argmin_pipe.sv
`default_nettype none
// ============================================================================
// distance_argmin_pipe : registered comparator tree picking the lowest-index
// nearest enabled core. Optional per-core hit counters: DISTANCE_ARGMIN_HIT_COUNT_EN.
// Revision: 1.0
// ============================================================================
module distance_argmin_pipe #(
  parameter int N_CORES = 16,
  parameter int DIST_W  = 11,
  parameter int TAG_W   = 8,
  parameter int IDX_W   = $clog2(N_CORES)
) (
  input  wire                   clk,
  input  wire                   rst_n,
`ifdef DISTANCE_ARGMIN_HIT_COUNT_EN
  input  wire                   clr_hits,
  output logic [N_CORES*16-1:0] hit_counts,
`endif
  distance_argmin_pipe_if.slave bus
);

  localparam int LEVELS = IDX_W;
  localparam int LEAVES = 1 << LEVELS;
  localparam int KEY_W  = DIST_W + 1;
  localparam logic [N_CORES-1:0] ONEHOT_LSB = {{(N_CORES-1){1'b0}}, 1'b1};

  // Heap-ordered tree: node n has children 2n and 2n+1; leaves are LEAVES..2*LEAVES-1.
  logic [KEY_W-1:0]  r_key [1:2*LEAVES-1];
  logic [IDX_W-1:0]  r_idx [1:LEAVES-1];
  logic [LEVELS:0]   r_vld;
  logic [TAG_W-1:0]  r_tag [0:LEVELS];

  logic [KEY_W-1:0]  w_leaf     [LEAVES];
  logic [KEY_W-1:0]  w_key      [1:LEAVES-1];
  logic [IDX_W-1:0]  w_idx      [1:LEAVES-1];
  logic [IDX_W-1:0]  w_node_idx [1:2*LEAVES-1];

  logic              r_out_valid;
  logic [N_CORES-1:0] r_out_onehot;
  logic [IDX_W-1:0]  r_out_idx;
  logic [DIST_W-1:0] r_out_min;
  logic              r_out_none;
  logic [TAG_W-1:0]  r_out_tag;

  logic              w_stall;
  logic              w_none;

  assign w_stall      = r_out_valid & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;

  // Key {~en, dist}: any enabled core beats every disabled core and padding leaf.
  generate
    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
      if (i < N_CORES) begin : g_core
        assign w_leaf[i] = {~bus.in_en[i], bus.in_dist[i*DIST_W +: DIST_W]};
      end else begin : g_pad
        assign w_leaf[i] = '1;
      end
    end
  endgenerate

  always_comb begin
    for (int n = 1; n < LEAVES; n++) begin
      w_node_idx[n] = r_idx[n];
    end
    for (int n = LEAVES; n < 2*LEAVES; n++) begin
      w_node_idx[n] = IDX_W'(n - LEAVES);
    end
    // Left child holds the lower indices, so it wins ties.
    for (int n = 1; n < LEAVES; n++) begin
      if (r_key[2*n] <= r_key[2*n+1]) begin
        w_key[n] = r_key[2*n];
        w_idx[n] = w_node_idx[2*n];
      end else begin
        w_key[n] = r_key[2*n+1];
        w_idx[n] = w_node_idx[2*n+1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int n = 1; n < 2*LEAVES; n++) r_key[n] <= '0;
      for (int n = 1; n < LEAVES; n++)   r_idx[n] <= '0;
      for (int l = 0; l <= LEVELS; l++)  r_tag[l] <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= bus.in_valid;
      r_tag[0] <= bus.in_tag;
      for (int i = 0; i < LEAVES; i++) r_key[LEAVES+i] <= w_leaf[i];
      for (int n = 1; n < LEAVES; n++) begin
        r_key[n] <= w_key[n];
        r_idx[n] <= w_idx[n];
      end
      for (int l = 1; l <= LEVELS; l++) begin
        r_vld[l] <= r_vld[l-1];
        r_tag[l] <= r_tag[l-1];
      end
    end
  end

  // Root key MSB set means even the best candidate was disabled.
  assign w_none = r_key[1][KEY_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_onehot <= '0;
      r_out_idx    <= '0;
      r_out_min    <= '0;
      r_out_none   <= 1'b0;
      r_out_tag    <= '0;
    end else if (!w_stall) begin
      r_out_valid  <= r_vld[LEVELS];
      r_out_tag    <= r_tag[LEVELS];
      r_out_none   <= w_none;
      r_out_idx    <= w_none ? '0 : r_idx[1];
      r_out_min    <= w_none ? '1 : r_key[1][DIST_W-1:0];
      r_out_onehot <= w_none ? '0 : (ONEHOT_LSB << r_idx[1]);
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_onehot = r_out_onehot;
  assign bus.out_idx    = r_out_idx;
  assign bus.out_min    = r_out_min;
  assign bus.out_none   = r_out_none;
  assign bus.out_tag    = r_out_tag;

`ifdef DISTANCE_ARGMIN_HIT_COUNT_EN
  logic w_take;
  assign w_take = r_out_valid & bus.out_ready & ~r_out_none;

  generate
    for (genvar i = 0; i < N_CORES; i++) begin : g_hit
      logic [15:0] r_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (clr_hits) begin
          r_cnt <= '0;
        end else if (w_take && (r_out_idx == IDX_W'(i)) && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
      assign hit_counts[i*16 +: 16] = r_cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: doc/distance_argmin_pipe.md
Name: distance_argmin_pipe

Overview:
- Pipelined, parametrised argmin over N_CORES candidate distances; selects the nearest enabled centroid core for one data point per cycle.
- Sits between the per-core distance calculators and the K-means assignment/accumulate stage.
- Adds to the existing 16x11-bit combinational comparator tree:
  - registered tree levels;
  - valid/ready handshake with backpressure;
  - binary index output and minimum-distance output;
  - explicit all-disabled flag;
  - a sideband tag that travels with each sample.

Parameters:
- N_CORES, 16, number of candidate distances; >= 2; need not be a power of 2.
- DIST_W, 11, width of each distance.
- TAG_W, 8, width of the sideband tag carried alongside each sample.
- IDX_W, $clog2(N_CORES), width of the binary index output (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_dist  in  N_CORES*DIST_W  packed distances; core i at [i*DIST_W +: DIST_W].
- in_en  in  N_CORES  per-core enable; a disabled core never wins.
- in_tag  in  TAG_W  sideband tag (point id), returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_onehot  out  N_CORES  one-hot winner; all zero when no core is enabled.
- out_idx  out  IDX_W  binary winner index.
- out_min  out  DIST_W  winning distance.
- out_none  out  1  no core was enabled for this sample.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all pipeline valid bits clear, so out_valid=0;
  - out_onehot=0, out_idx=0, out_min=0, out_none=0, out_tag=0;
  - in_ready=1 once rst_n is released.
- Reset mid-operation discards every in-flight sample; no partial results appear after release.
- Key comparison:
  - each candidate is compared as the key {~en, dist}, (DIST_W+1) bits, unsigned;
  - disabled cores therefore lose to any enabled core.
- Padding: when N_CORES is not a power of 2, the tree is padded to 2^IDX_W leaves with key = all ones and en=0.
- Tie-break: equal keys resolve to the lower index (the left operand wins on <=). This applies at every level, so the global winner is the lowest-index minimum.
- Pipeline structure:
  - stage 0 registers the inputs;
  - each of the LEVELS=$clog2(N_CORES) comparator levels is registered;
  - each registered level carries key, index and tag.
- Latency: a sample accepted on edge k produces out_valid=1 after edge k+LEVELS+1 when there is no stall. For N_CORES=16 that is 5 cycles.
- Throughput: one sample per cycle.
- Handshake:
  - a transfer occurs on any cycle where valid and ready are both 1;
  - stall = out_valid & ~out_ready; in_ready = ~stall;
  - during a stall every stage, including the output registers, holds its value;
  - output values stay stable while out_valid=1 and out_ready=0;
  - in_valid=0 inserts a bubble (the stage valid bit is cleared); bubbles are not compressed.
- Output derivation:
  - out_idx = index of the winner;
  - out_onehot = 1<<out_idx, forced to 0 when out_none=1;
  - out_min = dist field of the winning key.
- All disabled: out_none=1, out_onehot=0, out_idx=0, out_min = all ones.
- N_CORES=2: a single level, latency 2.

Optional Feature:
- Macro: DISTANCE_ARGMIN_HIT_COUNT_EN.
- When defined:
  - adds an input clr_hits (1 bit);
  - adds an output hit_counts (N_CORES*16), with counter i at [i*16 +: 16];
  - counter i increments on every output transfer (out_valid & out_ready) whose winner is i;
  - counters saturate at 16'hFFFF;
  - out_none results count nothing;
  - clr_hits zeroes all counters synchronously and takes priority over a simultaneous increment;
  - reset clears all counters to 0.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.
- Purpose: supplies per-cluster membership counts to the centroid update stage.

Test Plan:
- N_CORES=16, all enabled, d[i]=100+i except d[9]=7, tag=8'h3C, out_ready=1 -> after 5 cycles: out_valid=1, out_idx=9, out_onehot=16'h0200, out_min=7, out_tag=8'h3C, out_none=0.
- Tie check: d[3]=d[12]=5, all others 200 -> out_idx=3, out_onehot=16'h0008.
- Enable masking: d[0]=0 with en[0]=0, d[6]=50, others 60, all others enabled -> out_idx=6, out_min=50.
- in_en=0 -> out_none=1, out_onehot=0, out_idx=0, out_min=11'h7FF.
- Backpressure:
  - stimulus: stream 20 back-to-back samples with distinct tags, hold out_ready=0 for cycles 8-12;
  - response: in_ready=0 during the stall; outputs held stable; all 20 results delivered in order with correct idx and tag; no loss or duplication.
- Reset and hit counts:
  - stimulus: assert rst_n=0 with 4 samples in flight, release, send 3 new samples;
  - response: exactly 3 results appear.
  - with DISTANCE_ARGMIN_HIT_COUNT_EN: stimulus is 3 wins for core 2 then 1 for core 5 -> counter 2 = 3, counter 5 = 1; then pulse clr_hits -> all counters 0.
